// File: rtl/frame_writer.sv
// frame_writer: packs a raster stream of 8-bit palette indices into 128-bit words
// and writes them, one buffered word at a time, into the SDRAM back buffer.
module frame_writer #(
   parameter logic [21:0] ADDR1   = 22'h100000,
   parameter logic [21:0] ADDR2   = 22'h200000,
   parameter int          H_WORDS = 40,
   parameter int          V_LINES = 480
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         start,
   input  logic         frame_flip,
   input  logic         pix_valid,
   output logic         pix_ready,
   input  logic [7:0]   pix_index,
   output logic         sdram_wr,
   output logic [21:0]  sdram_addr,
   output logic [127:0] sdram_wdata,
   input  logic         sdram_ac,
   input  logic         sdram_Wait,
   output logic         busy,
   output logic         done
);
   localparam logic [14:0] LAST_WORD = 15'(H_WORDS * V_LINES - 1);
   typedef enum logic [1:0] {IDLE, FILL, FLUSH, DONE} state_t;
   state_t        state;
   logic [21:0]   base;
   logic [3:0]    pcnt;
   logic [14:0]   wcnt;
   logic [119:0]  pack;
   logic          full;
   logic          ack;
   logic          accept;
   logic          load;
   // sdram_addr/sdram_wdata double as the single-entry write buffer
   assign ack       = sdram_wr & sdram_ac;
   assign pix_ready = (state == FILL) & ~(&pcnt & full & ~ack);
   assign accept    = pix_valid & pix_ready;
   assign load      = accept & (&pcnt);
   assign busy      = (state == FILL) | (state == FLUSH);
   assign done      = state == DONE;
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         state       <= IDLE;
         base        <= '0;
         pcnt        <= '0;
         wcnt        <= '0;
         pack        <= '0;
         full        <= 1'b0;
         sdram_wr    <= 1'b0;
         sdram_addr  <= '0;
         sdram_wdata <= '0;
      end else begin
         if (accept) pcnt <= pcnt + 4'd1;
         if (accept & ~&pcnt) pack[{pcnt, 3'b000} +: 8] <= pix_index;
         if (load) begin
            sdram_wdata <= {pix_index, pack};
            sdram_addr  <= base + {7'd0, wcnt};
            wcnt        <= wcnt + 15'd1;
         end
         full     <= load | (full & ~ack);
         sdram_wr <= sdram_wr ? ~sdram_ac : full & ~sdram_Wait;
         case (state)
            IDLE:
               if (start) begin
                  state <= FILL;
                  base  <= frame_flip ? ADDR2 : ADDR1;
                  pcnt  <= '0;
                  wcnt  <= '0;
               end
            FILL:    if (load && wcnt == LAST_WORD) state <= FLUSH;
            FLUSH:   if (ack) state <= DONE;
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_frame_writer.sv
// tb_frame_writer: randomized frames checked against a word/ack-level model of the writer.
module tb_frame_writer;
   localparam int HW = 40, VL = 3, NW = HW * VL, NPIX = NW * 16;
   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic         start = 1'b0, frame_flip = 1'b0, pix_valid = 1'b0;
   logic         pix_ready;
   logic [7:0]   pix_index = '0;
   logic         sdram_wr;
   logic [21:0]  sdram_addr;
   logic [127:0] sdram_wdata;
   logic         sdram_ac = 1'b0, sdram_wait = 1'b0;
   logic         busy, done;
   int           vectors = 0, miscompares = 0;

   frame_writer #(.H_WORDS(HW), .V_LINES(VL)) dut (
      .clock(clock), .reset(reset), .start(start), .frame_flip(frame_flip),
      .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_index(pix_index),
      .sdram_wr(sdram_wr), .sdram_addr(sdram_addr), .sdram_wdata(sdram_wdata),
      .sdram_ac(sdram_ac), .sdram_Wait(sdram_wait), .busy(busy), .done(done));

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      start = 0; pix_valid = 0; sdram_ac = 0; sdram_wait = 0;
      reset = 1;
      tick();
      reset = 0;
      tick();
   endtask

   task automatic test_reset();
      reset = 1;
      repeat (2) tick();
      vectors++;
      if ({sdram_wr, pix_ready, busy, done} !== 4'b0) begin
         miscompares++;
         $display("FAIL reset_flags got wr/rdy/busy/done=%b want 0000", {sdram_wr, pix_ready, busy, done});
      end
      vectors++;
      if (sdram_addr !== 22'h0 || sdram_wdata !== 128'h0) begin
         miscompares++;
         $display("FAIL reset_bus got addr=%h data=%h want 0", sdram_addr, sdram_wdata);
      end
      reset = 0;
      tick();
      frame_flip = 0; start = 1;
      tick();
      start = 0;
      for (int i = 0; i < 16; i++) begin
         pix_valid = 1; pix_index = 8'(i);
         tick();
      end
      pix_valid = 0;
      for (int i = 0; i < 4 && !sdram_wr; i++) tick();
      vectors++;
      if (sdram_wr !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_setup sdram_wr got %b want 1", sdram_wr);
      end
      #2 reset = 1;
      #1;
      vectors++;
      if (sdram_wr !== 1'b0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_abort got wr=%b busy=%b want 0 0", sdram_wr, busy);
      end
      @(posedge clock);
      #1 reset = 0;
      pix_valid = 1;
      repeat (3) tick();
      vectors++;
      if (pix_ready !== 1'b0 || busy !== 1'b0 || sdram_wr !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_idle got rdy=%b busy=%b wr=%b want 0 0 0", pix_ready, busy, sdram_wr);
      end
      pix_valid = 0;
   endtask

   task automatic test_packing();
      frame_flip = 1; start = 1;
      tick();
      start = 0;
      for (int i = 0; i < 16; i++) begin
         pix_valid = 1; pix_index = 8'(i);
         tick();
      end
      pix_valid = 0;
      for (int i = 0; i < 4 && !sdram_wr; i++) tick();
      vectors++;
      if (sdram_wr !== 1'b1 || sdram_addr !== 22'h200000) begin
         miscompares++;
         $display("FAIL pack_addr got wr=%b addr=%h want 1 200000", sdram_wr, sdram_addr);
      end
      vectors++;
      if (sdram_wdata !== 128'h0F0E0D0C0B0A09080706050403020100) begin
         miscompares++;
         $display("FAIL pack_data got %h want 0f0e0d0c0b0a09080706050403020100", sdram_wdata);
      end
      do_reset();
   endtask

   task automatic test_wait();
      frame_flip = 0; sdram_wait = 1; start = 1;
      tick();
      start = 0;
      for (int i = 0; i < 16; i++) begin
         pix_valid = 1; pix_index = 8'(i + 16);
         tick();
      end
      pix_valid = 0;
      for (int i = 0; i < 8; i++) begin
         vectors++;
         if (sdram_wr !== 1'b0) begin
            miscompares++;
            $display("FAIL wait_block cycle %0d sdram_wr got %b want 0", i, sdram_wr);
         end
         tick();
      end
      sdram_wait = 0;
      tick();
      vectors++;
      if (sdram_wr !== 1'b1 || sdram_addr !== 22'h100000) begin
         miscompares++;
         $display("FAIL wait_release got wr=%b addr=%h want 1 100000", sdram_wr, sdram_addr);
      end
      sdram_wait = 1;
      for (int i = 0; i < 5; i++) begin
         tick();
         vectors++;
         if (sdram_wr !== 1'b1 || sdram_addr !== 22'h100000 || sdram_wdata[7:0] !== 8'h10) begin
            miscompares++;
            $display("FAIL wait_hold cycle %0d got wr=%b addr=%h want 1 100000", i, sdram_wr, sdram_addr);
         end
      end
      sdram_ac = 1;
      tick();
      sdram_ac = 0;
      vectors++;
      if (sdram_wr !== 1'b0) begin
         miscompares++;
         $display("FAIL wait_ack sdram_wr got %b want 0", sdram_wr);
      end
      do_reset();
   endtask

   // One full frame against a model that tracks only accepted pixels and acknowledged words.
   task automatic run_frame(input string name, input bit flip, input bit toggle, input int valid_pct,
                            input int max_dly, input int first_dly, input bit wait_rnd);
      byte unsigned pix[$];
      logic [21:0]  base;
      logic [127:0] w;
      int           pi, acks, cyc, dly;
      bit           pending, done_seen, c_wr, c_ac, c_wait, c_full, c_acc, p_wr, p_ac, p_wait, p_full, exp_wr, exp_rdy, exp_done;
      base = flip ? 22'h200000 : 22'h100000;
      for (int i = 0; i < NPIX; i++) pix.push_back(8'($urandom));
      frame_flip = flip; start = 1;
      tick();
      start = 0;
      vectors++;
      if (busy !== 1'b1) begin
         miscompares++;
         $display("FAIL %s_start busy got %b want 1", name, busy);
      end
      pi = 0; acks = 0; cyc = 0; dly = 0;
      pending = 0; done_seen = 0; p_wr = 0; p_ac = 0; p_wait = 0; p_full = 0;
      while (!done_seen && cyc < 20000) begin
         if (toggle) frame_flip = 1'($urandom_range(1));
         pix_valid = pi < NPIX && $urandom_range(99) < valid_pct;
         pix_index = pi < NPIX ? pix[pi] : 8'($urandom);
         sdram_wait = wait_rnd && $urandom_range(2) == 0;
         if (sdram_wr && !pending) begin
            pending = 1;
            dly = acks == 0 ? first_dly : $urandom_range(max_dly);
         end
         sdram_ac = pending ? dly == 0 : (pi / 16 == acks) && $urandom_range(3) == 0;
         if (pending && dly > 0) dly--;
         #1;
         exp_wr = p_wr ? !p_ac : p_full && !p_wait;
         vectors++;
         if (sdram_wr !== exp_wr) begin
            miscompares++;
            $display("FAIL %s_wr cycle %0d got %b want %b", name, cyc, sdram_wr, exp_wr);
         end
         exp_rdy = pi < NPIX && !(pi % 16 == 15 && pi / 16 > acks && !(sdram_wr && sdram_ac));
         vectors++;
         if (pix_ready !== exp_rdy) begin
            miscompares++;
            $display("FAIL %s_ready cycle %0d pixel %0d got %b want %b", name, cyc, pi, pix_ready, exp_rdy);
         end
         if (sdram_wr && acks < NW) begin
            for (int b = 0; b < 16; b++) w[8*b +: 8] = pix[16*acks + b];
            vectors++;
            if (sdram_addr !== base + 22'(acks) || sdram_wdata !== w) begin
               miscompares++;
               $display("FAIL %s_word %0d got addr=%h data=%h want addr=%h data=%h",
                        name, acks, sdram_addr, sdram_wdata, base + 22'(acks), w);
            end
         end
         vectors++;
         if (busy !== 1'b1 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_busy cycle %0d got busy=%b done=%b want 1 0", name, cyc, busy, done);
         end
         c_wr = sdram_wr; c_ac = sdram_ac; c_wait = sdram_wait;
         c_full = pi / 16 > acks; c_acc = pix_valid && pix_ready;
         @(posedge clock);
         #1;
         if (c_acc) pi++;
         if (c_wr && c_ac) begin
            acks++;
            pending = 0;
         end
         exp_done = c_wr && c_ac && acks == NW;
         vectors++;
         if (done !== exp_done) begin
            miscompares++;
            $display("FAIL %s_done cycle %0d got %b want %b", name, cyc, done, exp_done);
         end
         done_seen = done_seen || done === 1'b1 || exp_done;
         p_wr = c_wr; p_ac = c_ac; p_wait = c_wait; p_full = c_full;
         cyc++;
      end
      vectors++;
      if (!done_seen || acks != NW) begin
         miscompares++;
         $display("FAIL %s_count got %0d writes done=%b want %0d writes", name, acks, done_seen, NW);
      end
      pix_valid = 0; sdram_ac = 0; sdram_wait = 0;
      tick();
      vectors++;
      if ({done, busy, sdram_wr, pix_ready} !== 4'b0) begin
         miscompares++;
         $display("FAIL %s_end got done/busy/wr/rdy=%b want 0000", name, {done, busy, sdram_wr, pix_ready});
      end
   endtask

   task automatic test_full_frame();
      run_frame("full", 0, 1, 100, 0, 0, 0);
   endtask

   task automatic test_backpressure();
      run_frame("bp", 1, 0, 100, 0, 20, 0);
   endtask

   task automatic test_random();
      run_frame("rand", 1, 1, 70, 4, 3, 1);
   endtask

   task automatic test_back_to_back();
      run_frame("b2b_a", 0, 0, 100, 2, 0, 1);
      run_frame("b2b_b", 1, 1, 90, 1, 5, 0);
   endtask

   initial begin
      test_reset();
      do_reset();
      test_packing();
      test_wait();
      test_full_frame();
      test_backpressure();
      test_random();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
